// File: rtl/if_stage_pkg.sv
// if_stage_pkg: FSM state encodings, the fetched-entry record and the default NOP word
// shared by the fetch stage and its skid buffer.
package if_stage_pkg;
    typedef enum logic [1:0] {
        IF_ST_ISSUE = 2'd0,
        IF_ST_WAIT  = 2'd1,
        IF_ST_STALL = 2'd2
    } if_state_e;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } if_entry_t;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched {instr, pc, fault};
// clear wins over load, load wins over drain.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rest,
    input  logic      load,
    input  logic      drain,
    input  logic      clear,
    input  if_entry_t d,
    output logic      valid,
    output if_entry_t q
);
    logic      valid_q, valid_d;
    if_entry_t entry_q, entry_d;
    always_comb begin
        valid_d = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : valid_q;
        entry_d = load ? d : entry_q;
    end
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end
    assign valid = valid_q;
    assign q     = entry_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch over a req/ack memory port with one output register and one skid entry.
// IF_ALIGN_CHECK_EN: a misaligned pc_addr produces a faulted NOP instead of a memory request.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [31:0] pc_addr,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        id_ready,
    output logic        if_fault
);
    if_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d, out_valid_q, out_valid_d;
    if_entry_t   out_q, out_d, cap, skid_q;
    logic        misaligned, capture, cap_out, cap_skid, skid_drain, skid_valid;

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = pc_addr[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        capture    = !flush && ((state_q == IF_ST_WAIT && imem_ack && !drop_q) ||
                                (state_q == IF_ST_ISSUE && misaligned));
        cap.instr  = (state_q == IF_ST_ISSUE) ? NOP_INSTR : imem_rdata;
        cap.pc     = (state_q == IF_ST_ISSUE) ? pc_addr : addr_q;
        cap.fault  = state_q == IF_ST_ISSUE;
        cap_out    = capture && (!out_valid_q || id_ready);
        cap_skid   = capture && !cap_out;
        skid_drain = !flush && state_q == IF_ST_STALL && id_ready && skid_valid;
        state_d    = state_q;
        addr_d     = addr_q;
        drop_d     = drop_q;
        if (state_q == IF_ST_ISSUE) begin
            state_d = misaligned ? (cap_skid ? IF_ST_STALL : IF_ST_ISSUE) : IF_ST_WAIT;
            addr_d  = pc_addr;
            // a flush in the issue cycle still leaves a request in flight that must be discarded
            drop_d  = flush && !misaligned;
        end else if (state_q == IF_ST_WAIT) begin
            state_d = !imem_ack ? IF_ST_WAIT : cap_skid ? IF_ST_STALL : IF_ST_ISSUE;
            drop_d  = !imem_ack && (drop_q || flush);
        end else begin
            state_d = (flush || id_ready) ? IF_ST_ISSUE : IF_ST_STALL;
        end
        out_valid_d = flush ? 1'b0 : (cap_out || skid_drain) ? 1'b1 : id_ready ? 1'b0 : out_valid_q;
        out_d       = cap_out ? cap : skid_drain ? skid_q : out_q;
        imem_req    = !rest && ((state_q == IF_ST_ISSUE && !misaligned) || state_q == IF_ST_WAIT);
        imem_addr   = (!rest && state_q == IF_ST_ISSUE) ? pc_addr : addr_q;
        pc_en       = !rest && (flush || capture);
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q     <= IF_ST_ISSUE;
            addr_q      <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '{instr: NOP_INSTR, pc: RESET_PC, fault: 1'b0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rest  (rest),
        .load  (cap_skid),
        .drain (skid_drain),
        .clear (flush),
        .d     (cap),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign if_valid    = out_valid_q;
    assign if_instr    = out_valid_q ? out_q.instr : NOP_INSTR;
    assign if_pc       = out_q.pc;
    assign if_pc_plus4 = out_q.pc + 32'd4;
    assign if_fault    = out_valid_q & out_q.fault;
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC address, issues a read over a req/ack instruction-memory port and presents the instruction, its PC and PC+4 to decode with a valid/ready handshake.
- Drives `pc_en` so the PC register advances only when a fetch has been captured, or on a redirect.
- Holds one output register plus one skid entry so that memory responses are never lost under decode back-pressure.

Parameters:
- `RESET_PC`, 32'h0000_0000, value of `if_pc` and `imem_addr` after reset; matches the PC's initial address.
- `NOP_INSTR`, 32'h0000_0000, value driven on `if_instr` when the output is invalid or faulted.

Ports:
- `clk`  in  1  clock, rising edge.
- `rest`  in  1  reset; asynchronous, active-high.
- `pc_addr`  in  32  current PC value (PC `addr` output).
- `pc_en`  out  1  PC register loads `next_pc` on this edge when 1.
- `flush`  in  1  redirect from a later stage; discard all fetched and in-flight work.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  32  read address; stable while `imem_req`=1 until ack.
- `imem_ack`  in  1  one-cycle pulse, response valid.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `if_valid`  out  1  output register holds an instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc`+4, modulo 2^32.
- `id_ready`  in  1  decode accepts the output this cycle.
- `if_fault`  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset: every output is 0, except `if_pc`=`RESET_PC` and `imem_addr`=`RESET_PC`. `if_pc_plus4`=`RESET_PC`+4. The FSM enters `ISSUE`; the skid entry and the drop flag are cleared. Reset takes effect immediately, including mid-request.
- FSM states:
  - `ISSUE`:
    - `imem_req`=1 and `imem_addr` is latched from `pc_addr` on entry.
    - The first cycle after reset issues `pc_addr` combinationally, then holds it.
  - `WAIT`:
    - Request outstanding; `imem_req`=1 and `imem_addr` is frozen.
    - On `imem_ack`:
      - If the drop flag is set, clear it, discard the data, and go to `ISSUE` with the new `pc_addr`.
      - Else if the output is empty or `id_ready`=1, load the output register (`if_valid`=1), pulse `pc_en` for that cycle, and go to `ISSUE`.
      - Else write the skid entry, pulse `pc_en`, and go to `STALL`.
  - `STALL`:
    - `imem_req`=0.
    - When `id_ready`=1, the skid entry moves to the output register next edge, then go to `ISSUE`.
- `ISSUE` transitions to `WAIT` after one cycle. Latency is 1 cycle from ack to `if_valid`. With 1-cycle ack and `id_ready`=1, sustained throughput is 1 instruction per 2 cycles.
- Output register:
  - Holds its value while `if_valid`=1 and `id_ready`=0.
  - `if_valid` clears on `id_ready`=1 unless it is refilled in the same cycle.
  - Simultaneous drain and refill is allowed.
- `flush`:
  - Next edge, `if_valid`=0 and the skid entry is cleared.
  - `pc_en`=1 in the flush cycle so the redirect target loads.
  - If in `WAIT` with no ack this cycle, set the drop flag. The frozen address stays on the bus until ack; the request is never retracted.
  - If `flush` and `imem_ack` coincide, the data is discarded and the FSM goes to `ISSUE`.
  - `flush` has priority over capture and over `id_ready`.
- `pc_en` is never 1 for two consecutive cycles without an intervening ack or flush.
- `imem_addr` never changes while `imem_req`=1 and no ack has arrived.

Optional Feature:
- Macro: `IF_ALIGN_CHECK_EN`.
- Defined:
  - In `ISSUE`, if `pc_addr[1:0]`≠0, no request is issued.
  - The output loads next edge with `if_valid`=1, `if_fault`=1, `if_instr`=`NOP_INSTR`, `if_pc`=`pc_addr`.
  - `pc_en` pulses that cycle.
  - `if_fault` travels with the output register and skid entry.
- Undefined:
  - `if_fault` is tied to 0 and the low address bits are passed unchanged to `imem_addr`.

Decomposition:
- Shared package (the common include file): `IF_ST_ISSUE`, `IF_ST_WAIT` and `IF_ST_STALL` state encodings (2 bits) and the `NOP_INSTR` default.
- Sub-module `if_skid_buf`: a one-entry holding register for {instr, pc, fault} with load, drain and clear inputs. Instantiated once for the skid entry; the output register is inline.

Test Plan:
- Reset release with `pc_addr`=0, ack 1 cycle after each req, `id_ready`=1:
  - `imem_addr` sequence 0,4,8.
  - `if_valid` every 2nd cycle with `if_instr` matching memory.
  - `pc_en` pulses only on ack cycles.
- Back-pressure: `id_ready`=0 for 6 cycles after the first fetch (`pc_addr`=0x10, 0x14).
  - Output holds 0x10, the skid entry holds 0x14, `imem_req`=0 in `STALL`.
  - Release gives 0x10 then 0x14, none lost or duplicated.
- Flush while in `WAIT` for address 0x20 (ack delayed 3 cycles), redirect `pc_addr`=0x100:
  - `imem_addr` stays 0x20 until ack.
  - The 0x20 data never appears on `if_valid`.
  - The next request is 0x100.
- Flush coincident with `imem_ack` and `if_valid`=1, `id_ready`=0:
  - Next cycle `if_valid`=0 and the skid entry is empty.
  - The following request uses the new `pc_addr`.
- Assert `rest` mid-`WAIT`:
  - Outputs return to reset values within the same cycle.
  - An ack arriving after reset release for the old request is not issued and is ignored.
- With `IF_ALIGN_CHECK_EN`, `pc_addr`=0x22:
  - No `imem_req`.
  - `if_valid`=1, `if_fault`=1, `if_instr`=0, `if_pc`=0x22, `if_pc_plus4`=0x26.
